// File: rtl/gate_sweep_bist.sv
// rtl/gate_sweep_bist.sv - exhaustive self-checking sweep of the bitwise gate library
//
// Purpose: on start, walks every {b,a} operand pair through WIDTH-wide
// NAND-built gate arrays (NOT a, NAND, AND, OR, XOR). Each result is compared
// against a behavioural golden model. The block counts mismatching vectors
// and records the first failure.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             sweep request, honoured only in IDLE
//   inj_en, inj_sel   test hook: invert bit 0 of channel inj_sel (0..4)
//   busy, done        sweep in progress / one-cycle completion pulse
//   pass              last completed sweep had no mismatches
//   err_count         saturating count of mismatching vectors
//   first_err_*       operands and lowest channel of the first mismatch
//   cur_a, cur_b      operands currently applied to the gate arrays
module gate_sweep_bist #(
  parameter int WIDTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             inj_en,
  input  logic [2:0]       inj_sel,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b,
  output logic [2:0]       first_err_ch,
  output logic [WIDTH-1:0] cur_a,
  output logic [WIDTH-1:0] cur_b
);

  localparam int VW = 2 * WIDTH;
  localparam logic [VW-1:0]    VEC_LAST = '1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [VW-1:0]      r_vec;
  logic               r_mis_q;
  logic [VW-1:0]      r_mis_vec;
  logic [2:0]         r_mis_ch;
  logic [CNT_W-1:0]   r_err_count;
  logic               r_first_valid;
  logic [VW-1:0]      r_first_vec;
  logic [2:0]         r_first_ch;
  logic               r_pass;

  logic [WIDTH-1:0]   w_a, w_b;
  logic [WIDTH-1:0]   w_dut  [5];
  logic [WIDTH-1:0]   w_gold [5];
  logic [4:0]         w_ch_mis;
  logic               w_mis;
  logic [2:0]         w_mis_ch;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               w_capture;

  assign w_a = r_vec[WIDTH-1:0];
  assign w_b = r_vec[VW-1:WIDTH];

  // Device under test: every gate is built from 2-input NANDs so the sweep
  // exercises a structurally different netlist from the golden expressions.
  logic [WIDTH-1:0] w_not_a, w_not_b, w_nand, w_and, w_or, w_xor;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic w_xa, w_xb;
    assign w_not_a[i] = ~(w_a[i] & w_a[i]);
    assign w_not_b[i] = ~(w_b[i] & w_b[i]);
    assign w_nand[i]  = ~(w_a[i] & w_b[i]);
    assign w_and[i]   = ~(w_nand[i] & w_nand[i]);
    assign w_or[i]    = ~(w_not_a[i] & w_not_b[i]);
    assign w_xa       = ~(w_a[i] & w_nand[i]);
    assign w_xb       = ~(w_b[i] & w_nand[i]);
    assign w_xor[i]   = ~(w_xa & w_xb);
  end

  assign w_gold[0] = ~w_a;
  assign w_gold[1] = ~(w_a & w_b);
  assign w_gold[2] = w_a & w_b;
  assign w_gold[3] = w_a | w_b;
  assign w_gold[4] = w_a ^ w_b;

  // Injection flips bit 0 only, so one corrupted channel yields exactly one
  // mismatching vector per applied operand pair.
  logic [4:0] w_inj;
  assign w_inj[0] = inj_en && (inj_sel == 3'd0);
  assign w_inj[1] = inj_en && (inj_sel == 3'd1);
  assign w_inj[2] = inj_en && (inj_sel == 3'd2);
  assign w_inj[3] = inj_en && (inj_sel == 3'd3);
  assign w_inj[4] = inj_en && (inj_sel == 3'd4);

  assign w_dut[0] = w_not_a ^ WIDTH'(w_inj[0]);
  assign w_dut[1] = w_nand  ^ WIDTH'(w_inj[1]);
  assign w_dut[2] = w_and   ^ WIDTH'(w_inj[2]);
  assign w_dut[3] = w_or    ^ WIDTH'(w_inj[3]);
  assign w_dut[4] = w_xor   ^ WIDTH'(w_inj[4]);

  for (genvar c = 0; c < 5; c++) begin : g_cmp
    assign w_ch_mis[c] = |(w_dut[c] ^ w_gold[c]);
  end

  assign w_mis = |w_ch_mis;

  // Descending scan so the lowest mismatching channel index wins.
  always_comb begin
    w_mis_ch = 3'd0;
    for (int c = 4; c >= 0; c--) begin
      if (w_ch_mis[c]) w_mis_ch = 3'(c);
    end
  end

  // Accumulation works on the registered mismatch of the previous vector.
  assign w_cnt_next = (r_mis_q && (r_err_count != CNT_MAX)) ?
                      r_err_count + CNT_W'(1) : r_err_count;
  assign w_capture  = r_mis_q && !r_first_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (r_vec == VEC_LAST) w_state_nxt = S_DRAIN;
      S_DRAIN: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec         <= '0;
      r_mis_q       <= 1'b0;
      r_mis_vec     <= '0;
      r_mis_ch      <= 3'd0;
      r_err_count   <= '0;
      r_first_valid <= 1'b0;
      r_first_vec   <= '0;
      r_first_ch    <= 3'd0;
      r_pass        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_vec         <= '0;
            r_mis_q       <= 1'b0;
            r_err_count   <= '0;
            r_first_valid <= 1'b0;
            r_first_vec   <= '0;
            r_first_ch    <= 3'd0;
            r_pass        <= 1'b0;
          end
        end
        S_RUN: begin
          r_mis_q     <= w_mis;
          r_mis_vec   <= r_vec;
          r_mis_ch    <= w_mis_ch;
          r_err_count <= w_cnt_next;
          if (w_capture) begin
            r_first_valid <= 1'b1;
            r_first_vec   <= r_mis_vec;
            r_first_ch    <= r_mis_ch;
          end
          if (r_vec != VEC_LAST) r_vec <= r_vec + VW'(1);
        end
        S_DRAIN: begin
          r_err_count <= w_cnt_next;
          if (w_capture) begin
            r_first_valid <= 1'b1;
            r_first_vec   <= r_mis_vec;
            r_first_ch    <= r_mis_ch;
          end
          r_mis_q <= 1'b0;
          r_pass  <= (w_cnt_next == '0);
        end
        default: ;
      endcase
    end
  end

  assign busy            = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done            = (r_state == S_DONE);
  assign pass            = r_pass;
  assign err_count       = r_err_count;
  assign first_err_valid = r_first_valid;
  assign first_err_a     = r_first_vec[WIDTH-1:0];
  assign first_err_b     = r_first_vec[VW-1:WIDTH];
  assign first_err_ch    = r_first_ch;
  assign cur_a           = w_a;
  assign cur_b           = w_b;

endmodule

// File: tb/tb_gate_sweep_bist.sv
// tb/tb_gate_sweep_bist.sv - directed self-checking bench for gate_sweep_bist
module tb_gate_sweep_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut0: WIDTH=2, CNT_W=16
  logic        rst_n0, start0, inj_en0;
  logic [2:0]  inj_sel0;
  logic        busy0, done0, pass0, fev0;
  logic [15:0] err0;
  logic [1:0]  fa0, fb0, ca0, cb0;
  logic [2:0]  fch0;

  // dut1: WIDTH=2, CNT_W=3 (saturation)
  logic        rst_n1, start1, inj_en1;
  logic [2:0]  inj_sel1;
  logic        busy1, done1, pass1, fev1;
  logic [2:0]  err1;
  logic [1:0]  fa1, fb1, ca1, cb1;
  logic [2:0]  fch1;

  gate_sweep_bist #(.WIDTH(2), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n0), .start(start0), .inj_en(inj_en0), .inj_sel(inj_sel0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .first_err_valid(fev0), .first_err_a(fa0), .first_err_b(fb0), .first_err_ch(fch0),
    .cur_a(ca0), .cur_b(cb0)
  );

  gate_sweep_bist #(.WIDTH(2), .CNT_W(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n1), .start(start1), .inj_en(inj_en1), .inj_sel(inj_sel1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_err_valid(fev1), .first_err_a(fa1), .first_err_b(fb1), .first_err_ch(fch1),
    .cur_a(ca1), .cur_b(cb1)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // 0: none, 1: pulse inj on dut0 only at a=1 b=2, 2: extra start on dut1 mid-sweep
  int mode = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Starts a sweep on the selected instance and follows it to the done pulse.
  // lat = edges after the start edge until done is seen, busy_cyc = busy cycles before it.
  task automatic sweep(input int sel, output int lat, output int busy_cyc);
    logic d, b;
    lat = -1;
    busy_cyc = 0;
    @(negedge clk);
    if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (mode == 1) inj_en0 = (ca0 == 2'd1) && (cb0 == 2'd2);
      if (mode == 2) start1 = (k == 5);
      d = (sel == 0) ? done0 : done1;
      b = (sel == 0) ? busy0 : busy1;
      if (d) begin
        lat = k;
        break;
      end
      if (b) busy_cyc++;
      @(negedge clk);
    end
    if (mode == 1) inj_en0 = 1'b0;
    start1 = 1'b0;
    chk("sweep_latency", lat, 17);
    chk("busy_cycles", busy_cyc, 17);
    @(negedge clk);
    d = (sel == 0) ? done0 : done1;
    b = (sel == 0) ? busy0 : busy1;
    chk("done_one_cycle", d, 0);
    chk("busy_after_done", b, 0);
  endtask

  int lat, bc, done_seen;

  initial begin
    rst_n0 = 1'b0; start0 = 1'b0; inj_en0 = 1'b0; inj_sel0 = 3'd0;
    rst_n1 = 1'b0; start1 = 1'b0; inj_en1 = 1'b0; inj_sel1 = 3'd0;
    #1;
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_pass", pass0, 0);
    chk("rst_err", err0, 0);
    chk("rst_fev", fev0, 0);
    chk("rst_cur_a", ca0, 0);
    chk("rst_cur_b", cb0, 0);
    chk("rst1_err", err1, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n0 = 1'b1;
    rst_n1 = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy0, 0);

    // clean sweep
    sweep(0, lat, bc);
    chk("clean_pass", pass0, 1);
    chk("clean_err", err0, 0);
    chk("clean_fev", fev0, 0);
    chk("clean_cur_a", ca0, 3);
    chk("clean_cur_b", cb0, 3);

    // XOR corrupted on every vector
    inj_en0 = 1'b1; inj_sel0 = 3'd4;
    sweep(0, lat, bc);
    inj_en0 = 1'b0;
    chk("xor_err", err0, 16);
    chk("xor_pass", pass0, 0);
    chk("xor_fev", fev0, 1);
    chk("xor_fa", fa0, 0);
    chk("xor_fb", fb0, 0);
    chk("xor_fch", fch0, 4);

    // NAND corrupted only on a=1 b=2
    inj_sel0 = 3'd1; mode = 1;
    sweep(0, lat, bc);
    mode = 0;
    chk("one_err", err0, 1);
    chk("one_pass", pass0, 0);
    chk("one_fa", fa0, 1);
    chk("one_fb", fb0, 2);
    chk("one_fch", fch0, 1);

    // out-of-range channel select corrupts nothing
    inj_en0 = 1'b1; inj_sel0 = 3'd5;
    sweep(0, lat, bc);
    inj_en0 = 1'b0;
    chk("sel5_err", err0, 0);
    chk("sel5_pass", pass0, 1);
    chk("sel5_fev", fev0, 0);

    // saturation with a 3-bit counter, ignored mid-sweep start
    inj_en1 = 1'b1; inj_sel1 = 3'd0; mode = 2;
    sweep(1, lat, bc);
    mode = 0;
    inj_en1 = 1'b0;
    chk("sat_err", err1, 7);
    chk("sat_pass", pass1, 0);
    chk("sat_fa", fa1, 0);
    chk("sat_fb", fb1, 0);
    chk("sat_fch", fch1, 0);
    @(negedge clk);
    chk("sat_hold_err", err1, 7);
    sweep(1, lat, bc);
    chk("sat_clean_err", err1, 0);
    chk("sat_clean_pass", pass1, 1);

    // reset in the middle of a sweep at vector 5
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    lat = -1;
    for (int k = 0; k < 30; k++) begin
      if (ca0 == 2'd1 && cb0 == 2'd1 && busy0) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    chk("abort_reach_vec5", lat, 5);
    inj_en0 = 1'b1; inj_sel0 = 3'd2;
    @(negedge clk);
    rst_n0 = 1'b0;
    #1;
    chk("abort_busy", busy0, 0);
    chk("abort_err", err0, 0);
    chk("abort_fev", fev0, 0);
    chk("abort_cur_a", ca0, 0);
    inj_en0 = 1'b0;
    @(negedge clk);
    rst_n0 = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 25; k++) begin
      if (done0 || busy0) done_seen++;
      @(negedge clk);
    end
    chk("abort_no_done", done_seen, 0);
    sweep(0, lat, bc);
    chk("post_abort_err", err0, 0);
    chk("post_abort_pass", pass0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
